// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// conditional-branch funct3 codes and the saturating counter step.
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   function automatic cnt_e sat_next(input cnt_e cur, input logic taken);
      cnt_e nxt;
      case (cur)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = WNT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_bht_table.sv
// Branch history table: array of 2-bit saturating counters with an
// asynchronous read port and one saturating update port.
module bht_table
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output cnt_e             rd_cnt_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   cnt_e cnt_q [ENTRIES];
   cnt_e upd_cnt_d;

   // Read sees the stored value, so a same-cycle update is not bypassed.
   assign rd_cnt_o  = cnt_q[rd_idx_i];
   assign upd_cnt_d = sat_next(cnt_q[upd_idx_i], upd_taken_i);

   // Counter array storage: reset to weak-not-taken, one entry updated per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= WNT;
         end
      end else if (upd_en_i) begin
         cnt_q[upd_idx_i] <= upd_cnt_d;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: fetch-time prediction, execute-time resolution,
// mispredict detection and retired-branch statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int BHT_ENTRIES = 16,
   parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        fetch_valid,
   input  logic        fetch_is_branch,
   input  logic [31:0] fetch_pc,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic [2:0]  ex_funct3,
   input  logic        br_eq,
   input  logic        br_lt,
   output logic        ex_taken,
   output logic        mispredict,
   input  logic        stat_clr,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
);

   logic [IDX_W-1:0] fetch_idx_s;
   logic [IDX_W-1:0] ex_idx_s;
   cnt_e             rd_cnt_s;
   logic             legal_s;
   logic             taken_raw_s;
   logic             resolve_s;
   logic             upd_en_s;
   logic             pred_q;
   logic             pred_d;
   logic [31:0]      br_count_q;
   logic [31:0]      br_count_d;
   logic [31:0]      mispred_count_q;
   logic [31:0]      mispred_count_d;
   logic             unused_s;

   assign fetch_idx_s = fetch_pc[IDX_W+1:2];
   assign ex_idx_s    = ex_pc[IDX_W+1:2];
   assign unused_s    = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                          ex_pc[31:IDX_W+2], ex_pc[1:0], rd_cnt_s[0]};

   bht_table #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (fetch_idx_s),
      .rd_cnt_o    (rd_cnt_s),
      .upd_en_i    (upd_en_s),
      .upd_idx_i   (ex_idx_s),
      .upd_taken_i (ex_taken)
   );

   // Branch outcome decode from comparator flags.
   always_comb begin
      legal_s     = 1'b1;
      taken_raw_s = 1'b0;
      case (ex_funct3)
         BEQ:     taken_raw_s = br_eq;
         BNE:     taken_raw_s = ~br_eq;
         BLT:     taken_raw_s = br_lt;
         BGE:     taken_raw_s = ~br_lt;
         BLTU:    taken_raw_s = br_lt;
         BGEU:    taken_raw_s = ~br_lt;
         default: legal_s     = 1'b0;
      endcase
   end

   // Gating with rst keeps the resolve outputs quiet while reset is held.
   assign resolve_s  = ex_valid & ex_is_branch & legal_s & ~rst;
   assign ex_taken   = resolve_s & taken_raw_s;
   assign mispredict = resolve_s & (pred_q != ex_taken);
   assign pred_taken = fetch_valid & fetch_is_branch & rd_cnt_s[1];
   assign upd_en_s   = resolve_s & ~stall;

   // Next state of the carried prediction and the statistics counters.
   always_comb begin
      pred_d          = pred_q;
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
      if (stall) begin
         pred_d = pred_q;
      end else if (mispredict) begin
         pred_d = 1'b0;
      end else begin
         pred_d = pred_taken;
      end
      if (stat_clr) begin
         br_count_d      = 32'd0;
         mispred_count_d = 32'd0;
      end else if (upd_en_s) begin
         br_count_d      = br_count_q + 32'd1;
         mispred_count_d = mispred_count_q + {31'd0, mispredict};
      end else begin
         br_count_d      = br_count_q;
         mispred_count_d = mispred_count_q;
      end
   end

   // Prediction pipeline register and statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_q          <= 1'b0;
         br_count_q      <= 32'd0;
         mispred_count_q <= 32'd0;
      end else begin
         pred_q          <= pred_d;
         br_count_q      <= br_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   assign br_count      = br_count_q;
   assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        fetch_valid;
   logic        fetch_is_branch;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic [2:0]  ex_funct3;
   logic        br_eq;
   logic        br_lt;
   logic        ex_taken;
   logic        mispredict;
   logic        stat_clr;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   int n_assert;
   int n_fail;

   branch_predictor dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .fetch_valid     (fetch_valid),
      .fetch_is_branch (fetch_is_branch),
      .fetch_pc        (fetch_pc),
      .pred_taken      (pred_taken),
      .ex_valid        (ex_valid),
      .ex_is_branch    (ex_is_branch),
      .ex_pc           (ex_pc),
      .ex_funct3       (ex_funct3),
      .br_eq           (br_eq),
      .br_lt           (br_lt),
      .ex_taken        (ex_taken),
      .mispredict      (mispredict),
      .stat_clr        (stat_clr),
      .br_count        (br_count),
      .mispred_count   (mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [2:0] f3, input logic eq, input logic lt);
      ex_valid     = 1'b1;
      ex_is_branch = 1'b1;
      ex_pc        = pc;
      ex_funct3    = f3;
      br_eq        = eq;
      br_lt        = lt;
   endtask

   task automatic fetch(input logic v, input logic [31:0] pc);
      fetch_valid     = v;
      fetch_is_branch = v;
      fetch_pc        = pc;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1; stall = 1'b0; stat_clr = 1'b0;
      fetch(1'b0, 32'h0);
      ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0;
      ex_funct3 = 3'b000; br_eq = 1'b0; br_lt = 1'b0;
      #1;
      chk("rst_br_count", br_count, 32'h0);
      chk("rst_mispred_count", mispred_count, 32'h0);
      chk("rst_mispredict", {31'd0, mispredict}, 32'h0);

      // Every entry weak-not-taken after reset
      for (int i = 0; i < 16; i++) begin
         fetch(1'b1, 32'(i) << 2);
         #1;
         chk("rst_pred", {31'd0, pred_taken}, 32'h0);
         chk("rst_entry", {30'd0, dut.u_bht.cnt_q[i]}, 32'h1);
      end
      @(negedge clk);
      rst = 1'b0;
      fetch(1'b1, 32'h40);
      #1;
      chk("pc40_pred_init", {31'd0, pred_taken}, 32'h0);
      fetch(1'b0, 32'h0);
      tick();

      // Two taken BEQ at 0x40 with a fetch between them
      resolve(32'h40, 3'b000, 1'b1, 1'b0);
      #1;
      chk("r1_ex_taken", {31'd0, ex_taken}, 32'h1);
      chk("r1_mispredict", {31'd0, mispredict}, 32'h1);
      tick();
      chk("r1_cnt", {30'd0, dut.u_bht.cnt_q[0]}, 32'h2);
      ex_valid = 1'b0;
      fetch(1'b1, 32'h40);
      #1;
      chk("f_after_r1", {31'd0, pred_taken}, 32'h1);
      tick();
      fetch(1'b0, 32'h0);
      resolve(32'h40, 3'b000, 1'b1, 1'b0);
      #1;
      chk("r2_mispredict", {31'd0, mispredict}, 32'h0);
      tick();
      ex_valid = 1'b0;
      fetch(1'b1, 32'h40);
      #1;
      chk("r2_cnt", {30'd0, dut.u_bht.cnt_q[0]}, 32'h3);
      chk("f_after_r2", {31'd0, pred_taken}, 32'h1);
      chk("r2_br_count", br_count, 32'd2);
      chk("r2_mispred_count", mispred_count, 32'd1);
      fetch(1'b0, 32'h0);
      tick();

      // funct3 sweep with eq=0, lt=1 (no clock edge)
      resolve(32'h48, 3'b000, 1'b0, 1'b1); #1; chk("beq",  {31'd0, ex_taken}, 32'h0);
      ex_funct3 = 3'b001; #1; chk("bne",  {31'd0, ex_taken}, 32'h1);
      ex_funct3 = 3'b100; #1; chk("blt",  {31'd0, ex_taken}, 32'h1);
      ex_funct3 = 3'b101; #1; chk("bge",  {31'd0, ex_taken}, 32'h0);
      ex_funct3 = 3'b110; #1; chk("bltu", {31'd0, ex_taken}, 32'h1);
      ex_funct3 = 3'b111; #1; chk("bgeu", {31'd0, ex_taken}, 32'h0);
      ex_funct3 = 3'b011; #1; chk("f3_011", {31'd0, ex_taken}, 32'h0);
      ex_funct3 = 3'b010; #1;
      chk("f3_010", {31'd0, ex_taken}, 32'h0);
      chk("f3_010_misp", {31'd0, mispredict}, 32'h0);
      tick();
      chk("f3_010_br_count", br_count, 32'd2);
      chk("f3_010_cnt", {30'd0, dut.u_bht.cnt_q[2]}, 32'h1);

      // Same-index fetch read and taken update in one cycle
      fetch(1'b1, 32'h4C);
      resolve(32'h4C, 3'b000, 1'b1, 1'b0);
      #1;
      chk("same_idx_pred", {31'd0, pred_taken}, 32'h0);
      chk("same_idx_misp", {31'd0, mispredict}, 32'h1);
      tick();
      ex_valid = 1'b0;
      #1;
      chk("same_idx_next", {31'd0, pred_taken}, 32'h1);
      chk("same_idx_br", br_count, 32'd3);
      chk("same_idx_mis", mispred_count, 32'd2);
      tick();
      fetch(1'b0, 32'h0);

      // Stall for three cycles with a not-taken resolve; pred_q holds 1
      stall = 1'b1;
      resolve(32'h50, 3'b000, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_misp", {31'd0, mispredict}, 32'h1);
         tick();
      end
      chk("stall_br", br_count, 32'd3);
      chk("stall_mis", mispred_count, 32'd2);
      chk("stall_cnt", {30'd0, dut.u_bht.cnt_q[4]}, 32'h1);
      chk("stall_predq", {31'd0, mispredict}, 32'h1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("clr_br", br_count, 32'd0);
      chk("clr_mis", mispred_count, 32'd0);
      chk("clr_cnt3", {30'd0, dut.u_bht.cnt_q[3]}, 32'h2);
      stall = 1'b0;
      ex_valid = 1'b0;
      tick();

      // br_count wrap: preload all-ones then check the next value
      force dut.br_count_q = 32'hFFFF_FFFF;
      resolve(32'h54, 3'b000, 1'b1, 1'b0);
      #1;
      chk("wrap_out", br_count, 32'hFFFF_FFFF);
      chk("wrap_next", dut.br_count_d, 32'h0);
      ex_valid = 1'b0;
      #1;
      release dut.br_count_q;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("wrap_clr", br_count, 32'h0);

      // Reset asserted in the middle of a taken burst at 0x58
      fetch(1'b1, 32'h58);
      resolve(32'h58, 3'b000, 1'b1, 1'b0);
      tick();
      tick();
      chk("burst_pred", {31'd0, pred_taken}, 32'h1);
      chk("burst_br", br_count, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_br", br_count, 32'h0);
      chk("mid_rst_mis", mispred_count, 32'h0);
      chk("mid_rst_pred", {31'd0, pred_taken}, 32'h0);
      chk("mid_rst_misp", {31'd0, mispredict}, 32'h0);
      chk("mid_rst_taken", {31'd0, ex_taken}, 32'h0);
      chk("mid_rst_cnt", {30'd0, dut.u_bht.cnt_q[6]}, 32'h1);
      ex_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_pred", {31'd0, pred_taken}, 32'h0);
      chk("post_rst_misp", {31'd0, mispredict}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
